mem_access_stage: RTL and testbench

- Memory stage directly downstream of the execute stage.
- Consumes the ALU result as the address and rs2 as store data.
- Runs a request/acknowledge transaction with data memory and formats load data (byte/half extraction, sign/zero extension).
- Presents a registered writeback bundle. Stalls upstream while a memory transaction is outstanding.

---
 rtl/mem_stage_pkg.sv | 21 ++
 rtl/mem_load_align.sv | 31 +++
 rtl/mem_access_stage.sv | 217 +++++++++++++++++++++
 tb/tb_mem_access_stage.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_stage_pkg.sv
// Shared encodings for the memory-access stage: funct3 access codes, FSM states
// and byte-enable patterns.
package mem_stage_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [3:0] BE_BYTE0   = 4'b0001;
    localparam logic [3:0] BE_LO_HALF = 4'b0011;
    localparam logic [3:0] BE_HI_HALF = 4'b1100;
    localparam logic [3:0] BE_WORD    = 4'b1111;

    typedef enum logic {
        IDLE,
        WAIT
    } state_t;

endpackage

// File: rtl/mem_load_align.sv
// Load formatting: picks the byte/half lane addressed by addr[1:0] out of the
// read word and sign- or zero-extends it according to funct3.
module mem_load_align
    import mem_stage_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rdata,
    input  logic [1:0]       addr,
    input  logic [2:0]       funct3,
    output logic [WIDTH-1:0] data
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    always_comb begin
        // NOTE: every output of a combinational block gets a default first so no path leaves it unassigned (no latch).
        data      = rdata;
        byte_lane = rdata[{addr, 3'b000} +: 8];
        half_lane = addr[1] ? rdata[31:16] : rdata[15:0];
        case (funct3)
            F3_B:    data = {{(WIDTH-8){byte_lane[7]}}, byte_lane};
            F3_BU:   data = {{(WIDTH-8){1'b0}}, byte_lane};
            F3_H:    data = {{(WIDTH-16){half_lane[15]}}, half_lane};
            F3_HU:   data = {{(WIDTH-16){1'b0}}, half_lane};
            default: data = rdata;
        endcase
    end

endmodule

// File: rtl/mem_access_stage.sv
// Memory stage: issues req/ack data-memory transactions, formats loads and
// registers the writeback bundle. Optional ack timeout via MEM_ACK_TIMEOUT_EN.
module mem_access_stage
    import mem_stage_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int RD_BITS = 5,
    parameter int TIMEOUT = 16
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               valid_in,
    input  logic [WIDTH-1:0]   alu_result,
    input  logic [WIDTH-1:0]   store_data,
    input  logic               mem_read,
    input  logic               mem_write,
    input  logic [2:0]         funct3,
    input  logic [RD_BITS-1:0] rd_in,
    input  logic               reg_write_in,
    output logic               stall,
    output logic               dmem_req,
    output logic               dmem_we,
    output logic [WIDTH-1:0]   dmem_addr,
    output logic [3:0]         dmem_be,
    output logic [WIDTH-1:0]   dmem_wdata,
    input  logic               dmem_ack,
    input  logic [WIDTH-1:0]   dmem_rdata,
    output logic               wb_valid,
    output logic [WIDTH-1:0]   wb_data,
    output logic [RD_BITS-1:0] wb_rd,
    output logic               wb_reg_write,
    output logic               misaligned,
    output logic               bus_error
);

    state_t state, next_state;

    logic               is_mem;
    logic               access_legal;
    logic               accept_mem;
    logic               fault;
    logic               pass_through;
    logic               ack_done;
    logic               timeout_hit;
    logic [3:0]         next_be;
    logic [WIDTH-1:0]   next_wdata;
    logic [WIDTH-1:0]   load_data;

    logic [WIDTH-1:0]   req_addr;
    logic [2:0]         req_f3;
    logic               req_load;
    logic               req_we;
    logic [3:0]         req_be;
    logic [WIDTH-1:0]   req_wdata;
    logic [RD_BITS-1:0] req_rd;
    logic               req_rw;

    assign is_mem       = mem_read | mem_write;
    assign accept_mem   = (state == IDLE) && valid_in && is_mem && access_legal;
    assign fault        = (state == IDLE) && valid_in && is_mem && !access_legal;
    assign pass_through = (state == IDLE) && valid_in && !is_mem;
    assign ack_done     = (state == WAIT) && dmem_ack;

    always_comb begin
        access_legal = 1'b0;
        case (funct3)
            F3_B:    access_legal = 1'b1;
            F3_H:    access_legal = !alu_result[0];
            F3_W:    access_legal = (alu_result[1:0] == 2'b00);
            F3_BU:   access_legal = !mem_write;
            F3_HU:   access_legal = !mem_write && !alu_result[0];
            default: access_legal = 1'b0;
        endcase
        if (mem_read && mem_write)
            access_legal = 1'b0;
    end

    always_comb begin
        next_be    = BE_WORD;
        next_wdata = store_data;
        case (funct3[1:0])
            2'b00: begin
                next_be    = BE_BYTE0 << alu_result[1:0];
                next_wdata = {4{store_data[7:0]}};
            end
            2'b01: begin
                next_be    = alu_result[1] ? BE_HI_HALF : BE_LO_HALF;
                next_wdata = {2{store_data[15:0]}};
            end
            default: ;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!reset_n)
            state <= IDLE;
        else
            state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (accept_mem) next_state = WAIT;
            WAIT:    if (dmem_ack || timeout_hit) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Memory-side outputs are driven only in WAIT, so they read 0 whenever idle.
    always_comb begin
        stall      = 1'b0;
        dmem_req   = 1'b0;
        dmem_we    = 1'b0;
        dmem_addr  = '0;
        dmem_be    = '0;
        dmem_wdata = '0;
        case (state)
            IDLE: stall = accept_mem;
            WAIT: begin
                stall      = !dmem_ack && !timeout_hit;
                dmem_req   = 1'b1;
                dmem_we    = req_we;
                dmem_addr  = {req_addr[WIDTH-1:2], 2'b00};
                dmem_be    = req_be;
                dmem_wdata = req_wdata;
            end
            default: ;
        endcase
    end

    // NOTE: request capture registers carry no reset; they are only observed while in WAIT, which reset leaves.
    always_ff @(posedge clk) begin
        if (accept_mem) begin
            req_addr  <= alu_result;
            req_f3    <= funct3;
            req_load  <= mem_read;
            req_we    <= mem_write;
            req_be    <= next_be;
            req_wdata <= next_wdata;
            req_rd    <= rd_in;
            req_rw    <= reg_write_in;
        end
    end

    mem_load_align #(.WIDTH(WIDTH)) u_load_align (
        .rdata  (dmem_rdata),
        .addr   (req_addr[1:0]),
        .funct3 (req_f3),
        .data   (load_data)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wb_valid     <= 1'b0;
            wb_data      <= '0;
            wb_rd        <= '0;
            wb_reg_write <= 1'b0;
            misaligned   <= 1'b0;
        end else begin
            wb_valid   <= 1'b0;
            misaligned <= 1'b0;
            if (pass_through) begin
                wb_valid     <= 1'b1;
                wb_data      <= alu_result;
                wb_rd        <= rd_in;
                wb_reg_write <= reg_write_in;
            end else if (fault) begin
                wb_valid     <= 1'b1;
                misaligned   <= 1'b1;
                wb_data      <= '0;
                wb_rd        <= rd_in;
                wb_reg_write <= 1'b0;
            end else if (ack_done) begin
                wb_valid     <= 1'b1;
                wb_data      <= req_load ? load_data : '0;
                wb_rd        <= req_rd;
                wb_reg_write <= req_rw;
            end else if (timeout_hit) begin
                wb_valid     <= 1'b1;
                wb_data      <= '0;
                wb_rd        <= req_rd;
                wb_reg_write <= 1'b0;
            end
        end
    end

`ifdef MEM_ACK_TIMEOUT_EN
    localparam int CNT_BITS = $clog2(TIMEOUT + 1);

    logic [CNT_BITS-1:0] wait_cnt;

    // Counter sits at zero in IDLE, so it starts from zero on every WAIT entry.
    always_ff @(posedge clk) begin
        if (!reset_n || state == IDLE)
            wait_cnt <= '0;
        else
            wait_cnt <= wait_cnt + 1'b1;
    end

    assign timeout_hit = (state == WAIT) && !dmem_ack
                         && (wait_cnt == CNT_BITS'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (!reset_n)
            bus_error <= 1'b0;
        else
            bus_error <= timeout_hit;
    end
`else
    assign timeout_hit = 1'b0;
    assign bus_error   = 1'b0;
`endif

endmodule

// File: tb/tb_mem_access_stage.sv
// Randomized self-checking bench for mem_access_stage against an arithmetic
// reference model of access legality, byte enables, store replication and load extension.
module tb_mem_access_stage;

    localparam int WIDTH   = 32;
    localparam int RD_BITS = 5;
    localparam int TIMEOUT = 16;

    logic               clk = 1'b0;
    logic               reset_n;
    logic               valid_in;
    logic [WIDTH-1:0]   alu_result;
    logic [WIDTH-1:0]   store_data;
    logic               mem_read;
    logic               mem_write;
    logic [2:0]         funct3;
    logic [RD_BITS-1:0] rd_in;
    logic               reg_write_in;
    logic               stall;
    logic               dmem_req;
    logic               dmem_we;
    logic [WIDTH-1:0]   dmem_addr;
    logic [3:0]         dmem_be;
    logic [WIDTH-1:0]   dmem_wdata;
    logic               dmem_ack;
    logic [WIDTH-1:0]   dmem_rdata;
    logic               wb_valid;
    logic [WIDTH-1:0]   wb_data;
    logic [RD_BITS-1:0] wb_rd;
    logic               wb_reg_write;
    logic               misaligned;
    logic               bus_error;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] last_wb_data = '0;

    mem_access_stage #(.WIDTH(WIDTH), .RD_BITS(RD_BITS), .TIMEOUT(TIMEOUT)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .valid_in     (valid_in),
        .alu_result   (alu_result),
        .store_data   (store_data),
        .mem_read     (mem_read),
        .mem_write    (mem_write),
        .funct3       (funct3),
        .rd_in        (rd_in),
        .reg_write_in (reg_write_in),
        .stall        (stall),
        .dmem_req     (dmem_req),
        .dmem_we      (dmem_we),
        .dmem_addr    (dmem_addr),
        .dmem_be      (dmem_be),
        .dmem_wdata   (dmem_wdata),
        .dmem_ack     (dmem_ack),
        .dmem_rdata   (dmem_rdata),
        .wb_valid     (wb_valid),
        .wb_data      (wb_data),
        .wb_rd        (wb_rd),
        .wb_reg_write (wb_reg_write),
        .misaligned   (misaligned),
        .bus_error    (bus_error)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Reference model: access size in bytes from the low funct3 bits.
    function automatic int size_of(input logic [2:0] f3);
        return 1 << f3[1:0];
    endfunction

    function automatic bit legal_op(input bit rd_op, input bit wr_op,
                                    input logic [2:0] f3, input logic [31:0] addr);
        if (rd_op && wr_op) return 1'b0;
        if (!(f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101})) return 1'b0;
        if (wr_op && f3[2]) return 1'b0;
        return (addr % size_of(f3)) == 0;
    endfunction

    function automatic logic [3:0] exp_be(input logic [2:0] f3, input logic [31:0] addr);
        int v;
        v = ((1 << size_of(f3)) - 1) << (addr % 4);
        return v[3:0];
    endfunction

    function automatic logic [31:0] exp_wdata(input logic [2:0] f3, input logic [31:0] sd);
        logic [31:0] part;
        case (size_of(f3))
            1: begin part = 32'(sd[7:0]);  return part * 32'h0101_0101; end
            2: begin part = 32'(sd[15:0]); return part * 32'h0001_0001; end
            default: return sd;
        endcase
    endfunction

    function automatic logic [31:0] exp_load(input logic [2:0] f3, input logic [31:0] addr,
                                             input logic [31:0] rdata);
        logic [31:0] v;
        int bits;
        v    = rdata >> (8 * (addr % 4));
        bits = 8 * size_of(f3);
        if (bits < 32) begin
            v = v & ((32'h1 << bits) - 1);
            if (!f3[2] && v[bits-1]) v = v - (32'h1 << bits);
        end
        return v;
    endfunction

    // One instruction from presentation to retirement plus one idle cycle.
    // Called just after a falling edge; inputs stay held while the stage stalls.
    task automatic do_op(input bit rd_op, input bit wr_op, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] sd,
                         input logic [4:0] rd, input bit rw, input int delay,
                         input logic [31:0] rdata);
        bit          mem_op;
        bit          ok;
        logic [31:0] exp_data;
        mem_op = rd_op | wr_op;
        ok     = legal_op(rd_op, wr_op, f3, addr);
        valid_in     = 1'b1;
        alu_result   = addr;
        store_data   = sd;
        mem_read     = rd_op;
        mem_write    = wr_op;
        funct3       = f3;
        rd_in        = rd;
        reg_write_in = rw;
        dmem_ack     = 1'b0;
        dmem_rdata   = $urandom;
        #1;
        check("stall_accept", stall, 32'(mem_op && ok));
        @(negedge clk);
        if (mem_op && ok) begin
            for (int i = 0; i <= delay; i++) begin
                check("dmem_req", dmem_req, 1);
                check("dmem_we", dmem_we, 32'(wr_op));
                check("dmem_addr", dmem_addr, {addr[31:2], 2'b00});
                check("dmem_be", dmem_be, 32'(exp_be(f3, addr)));
                if (wr_op) check("dmem_wdata", dmem_wdata, exp_wdata(f3, sd));
                check("bus_error_wait", bus_error, 0);
                if (i < delay) begin
                    check("stall_wait", stall, 1);
                    @(negedge clk);
                end
            end
            dmem_ack   = 1'b1;
            dmem_rdata = rdata;
            #1;
            check("stall_ack", stall, 0);
            @(negedge clk);
            dmem_ack = 1'b0;
            valid_in = 1'b0;
            exp_data = rd_op ? exp_load(f3, addr, rdata) : 32'h0;
            check("wb_valid_mem", wb_valid, 1);
            check("wb_data_mem", wb_data, exp_data);
            check("wb_rd_mem", 32'(wb_rd), 32'(rd));
            check("wb_reg_write_mem", wb_reg_write, 32'(rw));
            check("misaligned_mem", misaligned, 0);
            check("req_after_ack", dmem_req, 0);
        end else begin
            exp_data = mem_op ? 32'h0 : addr;
            check("wb_valid_direct", wb_valid, 1);
            check("misaligned", misaligned, 32'(mem_op));
            check("wb_data_direct", wb_data, exp_data);
            check("wb_reg_write_direct", wb_reg_write, mem_op ? 32'h0 : 32'(rw));
            if (!mem_op) check("wb_rd_direct", 32'(wb_rd), 32'(rd));
            check("no_req", dmem_req, 0);
        end
        last_wb_data = exp_data;
        // Idle cycle with a stray ack that must be ignored.
        valid_in   = 1'b0;
        alu_result = $urandom;
        dmem_ack   = 1'($urandom);
        #1;
        check("stall_idle", stall, 0);
        @(negedge clk);
        dmem_ack = 1'b0;
        check("wb_valid_idle", wb_valid, 0);
        check("wb_data_hold", wb_data, last_wb_data);
        check("bus_error_idle", bus_error, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n      = 1'b0;
        valid_in     = 1'b0;
        alu_result   = '0;
        store_data   = '0;
        mem_read     = 1'b0;
        mem_write    = 1'b0;
        funct3       = '0;
        rd_in        = '0;
        reg_write_in = 1'b0;
        dmem_ack     = 1'b0;
        dmem_rdata   = '0;
        repeat (3) @(negedge clk);
        check("rst_wb_valid", wb_valid, 0);
        check("rst_wb_data", wb_data, 0);
        check("rst_wb_rd", 32'(wb_rd), 0);
        check("rst_wb_reg_write", wb_reg_write, 0);
        check("rst_misaligned", misaligned, 0);
        check("rst_bus_error", bus_error, 0);
        check("rst_stall", stall, 0);
        check("rst_dmem_req", dmem_req, 0);
        check("rst_dmem_we", dmem_we, 0);
        reset_n = 1'b1;
        @(negedge clk);

        // Directed cases: pass-through, LB, SH, misaligned LW.
        do_op(0, 0, 3'b000, 32'h0000_1234, 32'h0, 5'd5, 1, 0, 32'h0);
        do_op(1, 0, 3'b000, 32'h0000_0103, 32'h0, 5'd7, 1, 2, 32'h80FF_0000);
        do_op(0, 1, 3'b001, 32'h0000_0102, 32'hDEAD_BEEF, 5'd0, 0, 1, 32'h0);
        do_op(1, 0, 3'b010, 32'h0000_0101, 32'h0, 5'd9, 1, 0, 32'h0);
        do_op(1, 0, 3'b010, 32'h0000_0200, 32'h0, 5'd3, 1, 0, 32'h1234_5678);

        // Reset while an LHU is outstanding.
        valid_in     = 1'b1;
        alu_result   = 32'h0000_0100;
        mem_read     = 1'b1;
        mem_write    = 1'b0;
        funct3       = 3'b101;
        rd_in        = 5'd4;
        reg_write_in = 1'b1;
        @(negedge clk);
        check("lhu_req", dmem_req, 1);
        @(negedge clk);
        reset_n  = 1'b0;
        valid_in = 1'b0;
        @(negedge clk);
        check("rst_mid_req", dmem_req, 0);
        check("rst_mid_wb_valid", wb_valid, 0);
        check("rst_mid_wb_data", wb_data, 0);
        reset_n    = 1'b1;
        dmem_ack   = 1'b1;
        dmem_rdata = 32'hFFFF_FFFF;
        @(negedge clk);
        dmem_ack = 1'b0;
        check("late_ack_wb_valid", wb_valid, 0);
        check("late_ack_req", dmem_req, 0);
        check("late_ack_stall", stall, 0);
        last_wb_data = '0;

`ifdef MEM_ACK_TIMEOUT_EN
        // Ack never arrives: request holds for TIMEOUT cycles, then aborts.
        valid_in     = 1'b1;
        alu_result   = 32'h0000_0300;
        mem_read     = 1'b1;
        mem_write    = 1'b0;
        funct3       = 3'b010;
        rd_in        = 5'd8;
        reg_write_in = 1'b1;
        @(negedge clk);
        for (int i = 0; i < TIMEOUT; i++) begin
            check("to_req_held", dmem_req, 1);
            check("to_no_wb", wb_valid, 0);
            @(negedge clk);
        end
        valid_in = 1'b0;
        check("to_req_drop", dmem_req, 0);
        check("to_bus_error", bus_error, 1);
        check("to_wb_valid", wb_valid, 1);
        check("to_wb_reg_write", wb_reg_write, 0);
        @(negedge clk);
        check("to_bus_error_pulse", bus_error, 0);
        check("to_idle_req", dmem_req, 0);
`else
        // Without the timeout the request simply waits for a late ack.
        do_op(1, 0, 3'b001, 32'h0000_0302, 32'h0, 5'd8, 1, 40, 32'h8001_7FFF);
`endif

        for (int n = 0; n < 200; n++) begin
            int          kind;
            bit          rd_op;
            bit          wr_op;
            logic [2:0]  f3;
            logic [31:0] addr;
            kind  = $urandom_range(0, 9);
            rd_op = (kind >= 3 && kind <= 5) || kind == 9;
            wr_op = (kind >= 6);
            if ($urandom_range(0, 3) != 0) begin
                case ($urandom_range(0, 4))
                    0: f3 = 3'b000;
                    1: f3 = 3'b001;
                    2: f3 = 3'b010;
                    3: f3 = 3'b100;
                    default: f3 = 3'b101;
                endcase
            end else begin
                f3 = 3'($urandom);
            end
            addr = $urandom;
            do_op(rd_op, wr_op, f3, addr, $urandom, 5'($urandom),
                  wr_op ? 1'b0 : 1'($urandom), $urandom_range(0, 5), $urandom);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_checks, n_fail);
        $finish;
    end

endmodule
